dcache_req_sched: RTL

- Schedules dual-issue memory requests onto the single data-cache request port, in program order.
- Line1 is older and line2 is younger; both come from the EX stage.
- Tracks in-flight requests and remembers which line issued each one, so data_ok responses are routed back to the correct line.
- After an exception flush, counts responses that must be discarded; this is the bookkeeping the MEM stage needs from the cache side.

---
 rtl/dcache_req_sched_pkg.sv | 20 ++
 rtl/dcache_req_sched_sched_id_fifo.sv | 47 ++++
 rtl/dcache_req_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dcache_req_sched_pkg.sv
// Shared widths, line-id encoding and request-bus layout for the dcache request scheduler.
package dcache_req_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  typedef enum logic {
    LINE1 = 1'b0,
    LINE2 = 1'b1
  } line_id_e;

  // Packed request bus used between EX and MEM: {wr, wstrb, addr, wdata}
  localparam int REQ_WDATA_LSB = 0;
  localparam int REQ_ADDR_LSB  = REQ_WDATA_LSB + DATA_W;
  localparam int REQ_WSTRB_LSB = REQ_ADDR_LSB + ADDR_W;
  localparam int REQ_WR_BIT    = REQ_WSTRB_LSB + 4;
  localparam int REQ_BUS_W     = REQ_WR_BIT + 1;

endpackage

// File: rtl/dcache_req_sched_sched_id_fifo.sv
// Two-entry FIFO of 1-bit line ids; remembers which line issued each in-flight request.
module sched_id_fifo (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic pop_id,
  output logic full,
  output logic empty,
  output logic overflow,
  output logic underflow
);

  logic [1:0] mem;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign pop_id    = mem[rd_ptr];
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;
  // A pop in the same cycle frees the slot, so a push at full is still legal then
  assign do_push   = push & (~full | pop);
  assign do_pop    = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dcache_req_sched.sv
// Dual-issue to single-port dcache request scheduler with response routing and flush discard.
// Optional performance counters enabled by DCACHE_REQ_SCHED_PERF_EN.
module dcache_req_sched #(
  parameter int ADDR_W  = dcache_req_sched_pkg::ADDR_W,
  parameter int DATA_W  = dcache_req_sched_pkg::DATA_W,
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = dcache_req_sched_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              excep_flush_i,
  input  logic              line1_req_i,
  input  logic              line1_wr_i,
  input  logic [3:0]        line1_wstrb_i,
  input  logic [ADDR_W-1:0] line1_addr_i,
  input  logic [DATA_W-1:0] line1_wdata_i,
  output logic              line1_grant_o,
  input  logic              line2_req_i,
  input  logic              line2_wr_i,
  input  logic [3:0]        line2_wstrb_i,
  input  logic [ADDR_W-1:0] line2_addr_i,
  input  logic [DATA_W-1:0] line2_wdata_i,
  output logic              line2_grant_o,
  output logic              cache_req_o,
  output logic              cache_wr_o,
  output logic [3:0]        cache_wstrb_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [DATA_W-1:0] cache_wdata_o,
  input  logic              cache_addr_ok_i,
  input  logic              cache_data_ok_i,
  input  logic [DATA_W-1:0] cache_rdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_line_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic [CNT_W-1:0]  discard_o,
`ifdef DCACHE_REQ_SCHED_PERF_EN
  output logic [31:0]       perf_acc_cnt_o,
  output logic [31:0]       perf_drop_cnt_o,
  output logic [31:0]       perf_stall_cnt_o,
`endif
  output logic              error_o
);

  import dcache_req_sched_pkg::*;

  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] discard_q;
  logic [CNT_W-1:0] inflight_eff;
  logic [CNT_W-1:0] discard_nxt;
  logic             any_req;
  logic             rsp_pending;
  logic             drop_rsp;
  logic             accept;
  logic             sel_line2;
  logic             head_id;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic             fifo_udf;
  logic             err_set;
  line_id_e         push_id;

  assign any_req      = line1_req_i | line2_req_i;
  assign sel_line2    = ~line1_req_i;
  assign rsp_pending  = cache_data_ok_i & (inflight_q != '0);
  // A response returning this cycle frees its slot for a same-cycle accept
  assign inflight_eff = inflight_q - CNT_W'(rsp_pending);

  assign cache_req_o   = rst_n & any_req & ~excep_flush_i & (int'(inflight_eff) < MAX_OUT);
  assign accept        = cache_req_o & cache_addr_ok_i;
  assign line1_grant_o = accept & ~sel_line2;
  assign line2_grant_o = accept & sel_line2;
  assign push_id       = sel_line2 ? LINE2 : LINE1;

  assign cache_wr_o    = sel_line2 ? line2_wr_i    : line1_wr_i;
  assign cache_wstrb_o = sel_line2 ? line2_wstrb_i : line1_wstrb_i;
  assign cache_addr_o  = sel_line2 ? line2_addr_i  : line1_addr_i;
  assign cache_wdata_o = sel_line2 ? line2_wdata_i : line1_wdata_i;

  // Responses for instructions killed by a flush (including the flush cycle itself) are dropped
  assign drop_rsp    = rsp_pending & (excep_flush_i | (discard_q != '0));
  assign rsp_valid_o = rst_n & rsp_pending & ~drop_rsp;
  assign rsp_line_o  = head_id;
  assign rsp_rdata_o = cache_rdata_i;

  assign inflight_o = inflight_q;
  assign discard_o  = discard_q;

  always_comb begin
    discard_nxt = discard_q;
    if (excep_flush_i)
      discard_nxt = inflight_eff;
    else if (rsp_pending && (discard_q != '0))
      discard_nxt = discard_q - CNT_W'(1);
  end

  assign err_set = (cache_data_ok_i & (inflight_q == '0)) | (discard_q > inflight_q)
                 | fifo_ovf | fifo_udf;

  sched_id_fifo u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_id   (push_id),
    .pop       (cache_data_ok_i),
    .pop_id    (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .underflow (fifo_udf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      discard_q  <= '0;
      error_o    <= 1'b0;
    end else begin
      inflight_q <= inflight_eff + CNT_W'(accept);
      discard_q  <= discard_nxt;
      if (err_set) error_o <= 1'b1;
    end
  end

`ifdef DCACHE_REQ_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_acc_cnt_o   <= '0;
      perf_drop_cnt_o  <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      perf_acc_cnt_o   <= perf_acc_cnt_o + 32'(accept);
      perf_drop_cnt_o  <= perf_drop_cnt_o + 32'(drop_rsp);
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'(any_req & ~accept);
    end
  end
`endif

endmodule
